// File: rtl/dma_utils_pkg.sv
// Shared DMA types and helpers.
//   s_dma_axi_req_t  : burst request from the write streamer (valid, addr, alen, size, strb, mode)
//   s_dma_axi_resp_t : handshake back to the streamer (ready)
//   e_dma_mode_t     : addressing mode of a request
//   AXI_BURST_*      : AXI AWBURST encodings
//   e_w_state_t      : write-data channel FSM states
//   axi_burst_enc()  : maps a DMA mode onto an AWBURST encoding
`ifndef DMA_ADDR_WIDTH
`define DMA_ADDR_WIDTH 32
`endif
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 32
`endif

package dma_utils_pkg;

   typedef enum logic [1:0] {
      DMA_MODE_INCR  = 2'd0,
      DMA_MODE_FIXED = 2'd1
   } e_dma_mode_t;

   typedef struct packed {
      logic                             valid;
      logic [`DMA_ADDR_WIDTH-1:0]       addr;
      logic [7:0]                       alen;
      logic [2:0]                       size;
      logic [`DMA_DATA_WIDTH/8-1:0]     strb;
      e_dma_mode_t                      mode;
   } s_dma_axi_req_t;

   typedef struct packed {
      logic ready;
   } s_dma_axi_resp_t;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

   typedef enum logic {
      W_IDLE  = 1'b0,
      W_BEATS = 1'b1
   } e_w_state_t;

   function automatic logic [1:0] axi_burst_enc(input e_dma_mode_t mode);
      return (mode == DMA_MODE_FIXED) ? AXI_BURST_FIXED : AXI_BURST_INCR;
   endfunction

endpackage

// File: rtl/dma_cmd_fifo.sv
// Small synchronous FIFO holding per-burst write-channel commands.
//   clk, rst       : clock, synchronous active-high reset (clears pointers only)
//   push_i, din_i  : write one entry (ignored when full)
//   pop_i, dout_o  : drop the head entry (ignored when empty); dout_o shows the head
//   full_o, empty_o: occupancy flags
module dma_cmd_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             push_ok, pop_ok;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: entries are only visible between the pointers.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/dma_axi_wr_engine.sv
// AXI write-channel engine for the DMA write path.
// Accepts burst requests from the write streamer, issues them on AW, streams the
// matching data beats from an external data FIFO on W, and counts B responses.
//   clk, rst                 : clock, synchronous active-high reset
//   dma_axi_req_i/_resp_o    : request handshake with the write streamer
//   dma_abort_i              : stops new acceptances; accepted bursts still complete
//   aw*_o / awready_i        : AXI write-address channel
//   w*_o  / wready_i         : AXI write-data channel
//   bvalid_i, bresp_i, bready_o : AXI write-response channel
//   fifo_data_i, fifo_empty_i, fifo_pop_o : write-data FIFO read side
//   wr_err_o                 : sticky non-OKAY response seen
//   wr_idle_o                : nothing pending anywhere in the engine
module dma_axi_wr_engine
   import dma_utils_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  s_dma_axi_req_t                 dma_axi_req_i,
   output s_dma_axi_resp_t                dma_axi_resp_o,
   input  logic                           dma_abort_i,
   output logic                           awvalid_o,
   input  logic                           awready_i,
   output logic [`DMA_ADDR_WIDTH-1:0]     awaddr_o,
   output logic [7:0]                     awlen_o,
   output logic [2:0]                     awsize_o,
   output logic [1:0]                     awburst_o,
   output logic                           wvalid_o,
   input  logic                           wready_i,
   output logic [`DMA_DATA_WIDTH-1:0]     wdata_o,
   output logic [`DMA_DATA_WIDTH/8-1:0]   wstrb_o,
   output logic                           wlast_o,
   input  logic                           bvalid_i,
   input  logic [1:0]                     bresp_i,
   output logic                           bready_o,
   input  logic [`DMA_DATA_WIDTH-1:0]     fifo_data_i,
   input  logic                           fifo_empty_i,
   output logic                           fifo_pop_o,
   output logic                           wr_err_o,
   output logic                           wr_idle_o
);

   localparam int STRB_W = `DMA_DATA_WIDTH / 8;
   localparam int CMD_W  = 8 + STRB_W;
   localparam int OCNT_W = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [OCNT_W-1:0] OCNT_MAX = OCNT_W'(MAX_OUTSTANDING);
   localparam logic [OCNT_W-1:0] OCNT_ONE = 1;

   // AW stage
   logic                         awvalid_q, awvalid_d;
   logic [`DMA_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [7:0]                   awlen_q, awlen_d;
   logic [2:0]                   awsize_q, awsize_d;
   logic [1:0]                   awburst_q, awburst_d;
   // W FSM and the command it is working on
   e_w_state_t                   state_q, state_d;
   logic [7:0]                   beat_cnt_q, beat_cnt_d;
   logic [7:0]                   cur_alen_q, cur_alen_d;
   logic [STRB_W-1:0]            cur_strb_q, cur_strb_d;
   // B tracking and status
   logic [OCNT_W-1:0]            ocnt_q, ocnt_d;
   logic                         wr_err_q, wr_err_d;
   logic                         bready_q, bready_d;

   logic              ready, accept, aw_hs, w_hs, b_hs;
   logic              cmd_pop, cmd_full, cmd_empty;
   logic [CMD_W-1:0]  cmd_dout;

   // rst gates ready so nothing is accepted in the reset cycle itself.
   assign ready  = !rst && !awvalid_q && !cmd_full && (ocnt_q < OCNT_MAX) && !dma_abort_i;
   assign accept = dma_axi_req_i.valid && ready;
   assign aw_hs  = awvalid_q && awready_i;
   assign w_hs   = wvalid_o && wready_i;
   assign b_hs   = bvalid_i && bready_q;

   assign dma_axi_resp_o.ready = ready;

   // Commands queue in acceptance order, which fixes the W beat order
   // independently of when the AW handshakes happen.
   assign cmd_pop = (state_q == W_IDLE) && !cmd_empty;

   dma_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (MAX_OUTSTANDING)
   ) u_cmd_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (accept),
      .din_i   ({dma_axi_req_i.alen, dma_axi_req_i.strb}),
      .pop_i   (cmd_pop),
      .dout_o  (cmd_dout),
      .full_o  (cmd_full),
      .empty_o (cmd_empty)
   );

   always_comb begin
      awvalid_d  = awvalid_q;
      awaddr_d   = awaddr_q;
      awlen_d    = awlen_q;
      awsize_d   = awsize_q;
      awburst_d  = awburst_q;
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      cur_alen_d = cur_alen_q;
      cur_strb_d = cur_strb_q;
      ocnt_d     = ocnt_q;
      wr_err_d   = wr_err_q | (b_hs && (bresp_i != 2'b00));
      bready_d   = 1'b1;

      // Accept only happens with the stage empty, so it never collides with aw_hs.
      if (aw_hs) awvalid_d = 1'b0;
      if (accept) begin
         awvalid_d = 1'b1;
         awaddr_d  = dma_axi_req_i.addr;
         awlen_d   = dma_axi_req_i.alen;
         awsize_d  = dma_axi_req_i.size;
         awburst_d = axi_burst_enc(dma_axi_req_i.mode);
      end

      // Saturating guards keep the counter from wrapping on protocol misuse.
      if (aw_hs && !b_hs && (ocnt_q != OCNT_MAX))
         ocnt_d = ocnt_q + OCNT_ONE;
      else if (b_hs && !aw_hs && (ocnt_q != '0))
         ocnt_d = ocnt_q - OCNT_ONE;

      case (state_q)
         W_IDLE: begin
            if (!cmd_empty) begin
               state_d    = W_BEATS;
               beat_cnt_d = 8'd0;
               cur_alen_d = cmd_dout[CMD_W-1:STRB_W];
               cur_strb_d = cmd_dout[STRB_W-1:0];
            end
         end
         W_BEATS: begin
            if (w_hs) begin
               if (wlast_o) state_d = W_IDLE;
               else         beat_cnt_d = beat_cnt_q + 8'd1;
            end
         end
         default: state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         awvalid_q  <= 1'b0;
         awaddr_q   <= '0;
         awlen_q    <= '0;
         awsize_q   <= '0;
         awburst_q  <= '0;
         state_q    <= W_IDLE;
         beat_cnt_q <= '0;
         cur_alen_q <= '0;
         cur_strb_q <= '0;
         ocnt_q     <= '0;
         wr_err_q   <= 1'b0;
         bready_q   <= 1'b0;
      end else begin
         awvalid_q  <= awvalid_d;
         awaddr_q   <= awaddr_d;
         awlen_q    <= awlen_d;
         awsize_q   <= awsize_d;
         awburst_q  <= awburst_d;
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         cur_alen_q <= cur_alen_d;
         cur_strb_q <= cur_strb_d;
         ocnt_q     <= ocnt_d;
         wr_err_q   <= wr_err_d;
         bready_q   <= bready_d;
      end
   end

   assign awvalid_o  = awvalid_q;
   assign awaddr_o   = awaddr_q;
   assign awlen_o    = awlen_q;
   assign awsize_o   = awsize_q;
   assign awburst_o  = awburst_q;

   assign wvalid_o   = (state_q == W_BEATS) && !fifo_empty_i;
   assign wdata_o    = fifo_data_i;
   assign fifo_pop_o = w_hs;
   assign wlast_o    = (state_q == W_BEATS) && (beat_cnt_q == cur_alen_q);
   // Byte strobes apply only to single-beat bursts; longer bursts write full words.
   assign wstrb_o    = (cur_alen_q == 8'd0) ? cur_strb_q : {STRB_W{1'b1}};

   assign bready_o   = bready_q;
   assign wr_err_o   = wr_err_q;
   assign wr_idle_o  = !awvalid_q && cmd_empty && (state_q == W_IDLE) && (ocnt_q == '0);

endmodule

// File: tb/tb_dma_axi_wr_engine.sv
// Directed testbench for dma_axi_wr_engine (MAX_OUTSTANDING = 4, 32-bit data).
`ifndef DMA_ADDR_WIDTH
`define DMA_ADDR_WIDTH 32
`endif
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 32
`endif

module tb_dma_axi_wr_engine;
   import dma_utils_pkg::*;

   logic            clk;
   logic            rst;
   s_dma_axi_req_t  req;
   s_dma_axi_resp_t resp;
   logic            abort;
   logic            awvalid, awready;
   logic [31:0]     awaddr;
   logic [7:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;
   logic            wvalid, wready, wlast;
   logic [31:0]     wdata;
   logic [3:0]      wstrb;
   logic            bvalid, bready;
   logic [1:0]      bresp;
   logic [31:0]     fifo_data;
   logic            fifo_empty, fifo_pop;
   logic            wr_err, wr_idle;

   int checks = 0;
   int errors = 0;

   dma_axi_wr_engine #(.MAX_OUTSTANDING(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .dma_axi_req_i  (req),
      .dma_axi_resp_o (resp),
      .dma_abort_i    (abort),
      .awvalid_o      (awvalid),
      .awready_i      (awready),
      .awaddr_o       (awaddr),
      .awlen_o        (awlen),
      .awsize_o       (awsize),
      .awburst_o      (awburst),
      .wvalid_o       (wvalid),
      .wready_i       (wready),
      .wdata_o        (wdata),
      .wstrb_o        (wstrb),
      .wlast_o        (wlast),
      .bvalid_i       (bvalid),
      .bresp_i        (bresp),
      .bready_o       (bready),
      .fifo_data_i    (fifo_data),
      .fifo_empty_i   (fifo_empty),
      .fifo_pop_o     (fifo_pop),
      .wr_err_o       (wr_err),
      .wr_idle_o      (wr_idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout got running exp finished");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one request and returns one step after the accepting edge.
   task automatic send_req(input logic [31:0] a, input logic [7:0] l,
                           input logic [3:0] s, input e_dma_mode_t m);
      int n;
      req.valid = 1'b1; req.addr = a; req.alen = l; req.size = 3'd2;
      req.strb = s; req.mode = m;
      #1;
      n = 0;
      while (!resp.ready && n < 50) begin
         tick(); #1; n++;
      end
      checks++;
      if (resp.ready !== 1'b1) begin
         errors++;
         $display("FAIL send_req_ready addr %h got %b exp 1", a, resp.ready);
      end
      tick();
      req.valid = 1'b0;
   endtask

   task automatic b_pulse(input logic [1:0] r);
      bvalid = 1'b1; bresp = r;
      tick();
      bvalid = 1'b0; bresp = 2'b00;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick(); #1;
      checks++; if (resp.ready !== 1'b0)   begin errors++; $display("FAIL reset_ready got %b exp 0", resp.ready); end
      checks++; if (awvalid !== 1'b0)      begin errors++; $display("FAIL reset_awvalid got %b exp 0", awvalid); end
      checks++; if (wvalid !== 1'b0)       begin errors++; $display("FAIL reset_wvalid got %b exp 0", wvalid); end
      checks++; if (wlast !== 1'b0)        begin errors++; $display("FAIL reset_wlast got %b exp 0", wlast); end
      checks++; if (fifo_pop !== 1'b0)     begin errors++; $display("FAIL reset_pop got %b exp 0", fifo_pop); end
      checks++; if (bready !== 1'b0)       begin errors++; $display("FAIL reset_bready got %b exp 0", bready); end
      checks++; if (wr_err !== 1'b0)       begin errors++; $display("FAIL reset_err got %b exp 0", wr_err); end
      checks++; if (wr_idle !== 1'b1)      begin errors++; $display("FAIL reset_idle got %b exp 1", wr_idle); end
      checks++; if ({awaddr, awlen, awsize, awburst} !== 45'd0)
         begin errors++; $display("FAIL reset_aw_fields got %h exp 0", {awaddr, awlen, awsize, awburst}); end
      rst = 1'b0;
      tick(); #1;
      checks++; if (bready !== 1'b1)       begin errors++; $display("FAIL post_reset_bready got %b exp 1", bready); end
      checks++; if (resp.ready !== 1'b1)   begin errors++; $display("FAIL post_reset_ready got %b exp 1", resp.ready); end
   endtask

   task automatic test_incr_burst();
      send_req(32'h1000, 8'd3, 4'hF, DMA_MODE_INCR);
      #1;
      checks++; if (awvalid !== 1'b1)      begin errors++; $display("FAIL incr_awvalid got %b exp 1", awvalid); end
      checks++; if (awaddr !== 32'h1000)   begin errors++; $display("FAIL incr_awaddr got %h exp 1000", awaddr); end
      checks++; if (awlen !== 8'd3)        begin errors++; $display("FAIL incr_awlen got %0d exp 3", awlen); end
      checks++; if (awburst !== 2'b01)     begin errors++; $display("FAIL incr_awburst got %b exp 01", awburst); end
      checks++; if (awsize !== 3'd2)       begin errors++; $display("FAIL incr_awsize got %0d exp 2", awsize); end
      for (int b = 0; b < 4; b++) begin
         tick();
         fifo_data = 32'hA500_0000 + b;
         #1;
         checks++; if (wvalid !== 1'b1)    begin errors++; $display("FAIL incr_wvalid beat %0d got %b exp 1", b, wvalid); end
         checks++; if (wlast !== (b == 3)) begin errors++; $display("FAIL incr_wlast beat %0d got %b exp %b", b, wlast, (b == 3)); end
         checks++; if (wstrb !== 4'hF)     begin errors++; $display("FAIL incr_wstrb beat %0d got %h exp f", b, wstrb); end
         checks++; if (wdata !== 32'hA500_0000 + b)
            begin errors++; $display("FAIL incr_wdata beat %0d got %h exp %h", b, wdata, 32'hA500_0000 + b); end
         checks++; if (fifo_pop !== 1'b1)  begin errors++; $display("FAIL incr_pop beat %0d got %b exp 1", b, fifo_pop); end
         if (b == 0) begin
            checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL incr_aw_cleared got %b exp 0", awvalid); end
         end
      end
      tick(); #1;
      checks++; if (wvalid !== 1'b0)       begin errors++; $display("FAIL incr_wvalid_after got %b exp 0", wvalid); end
      checks++; if (wr_idle !== 1'b0)      begin errors++; $display("FAIL incr_idle_before_b got %b exp 0", wr_idle); end
      b_pulse(2'b00); #1;
      checks++; if (wr_idle !== 1'b1)      begin errors++; $display("FAIL incr_idle_after_b got %b exp 1", wr_idle); end
      checks++; if (wr_err !== 1'b0)       begin errors++; $display("FAIL incr_err got %b exp 0", wr_err); end
   endtask

   task automatic test_single_beat();
      send_req(32'h1100, 8'd0, 4'b0110, DMA_MODE_FIXED);
      #1;
      checks++; if (awburst !== 2'b00)     begin errors++; $display("FAIL single_awburst got %b exp 00", awburst); end
      tick(); #1;
      checks++; if (wvalid !== 1'b1)       begin errors++; $display("FAIL single_wvalid got %b exp 1", wvalid); end
      checks++; if (wlast !== 1'b1)        begin errors++; $display("FAIL single_wlast got %b exp 1", wlast); end
      checks++; if (wstrb !== 4'b0110)     begin errors++; $display("FAIL single_wstrb got %b exp 0110", wstrb); end
      tick(); #1;
      checks++; if (wvalid !== 1'b0)       begin errors++; $display("FAIL single_wvalid_after got %b exp 0", wvalid); end
      b_pulse(2'b00); #1;
      checks++; if (wr_idle !== 1'b1)      begin errors++; $display("FAIL single_idle got %b exp 1", wr_idle); end
   endtask

   task automatic test_outstanding();
      int n_acc;
      n_acc = 0;
      req.valid = 1'b1; req.alen = 8'd0; req.size = 3'd2; req.strb = 4'hF; req.mode = DMA_MODE_INCR;
      for (int c = 0; c < 40; c++) begin
         req.addr = 32'h3000 + n_acc * 16;
         #1;
         if (resp.ready) n_acc++;
         tick();
      end
      #1;
      checks++; if (n_acc !== 4)           begin errors++; $display("FAIL outst_accepted got %0d exp 4", n_acc); end
      checks++; if (resp.ready !== 1'b0)   begin errors++; $display("FAIL outst_ready_full got %b exp 0", resp.ready); end
      bvalid = 1'b1; bresp = 2'b00;
      #1;
      checks++; if (resp.ready !== 1'b0)   begin errors++; $display("FAIL outst_ready_during_b got %b exp 0", resp.ready); end
      tick();
      bvalid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (req.valid && resp.ready) begin
            n_acc++;
            tick();
            req.valid = 1'b0;
         end else begin
            tick();
         end
      end
      checks++; if (n_acc !== 5)           begin errors++; $display("FAIL outst_fifth got %0d exp 5", n_acc); end
      req.valid = 1'b0;
      bvalid = 1'b1;
      for (int c = 0; c < 4; c++) tick();
      bvalid = 1'b0;
      tick(); tick(); #1;
      checks++; if (wr_idle !== 1'b1)      begin errors++; $display("FAIL outst_idle got %b exp 1", wr_idle); end
   endtask

   task automatic test_aw_stall();
      int pops, last_pops;
      pops = 0; last_pops = 0;
      awready = 1'b0;
      send_req(32'h2000, 8'd1, 4'hF, DMA_MODE_INCR);
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (awvalid !== 1'b1)    begin errors++; $display("FAIL stall_awvalid cyc %0d got %b exp 1", i, awvalid); end
         checks++; if (awaddr !== 32'h2000) begin errors++; $display("FAIL stall_awaddr cyc %0d got %h exp 2000", i, awaddr); end
         if (fifo_pop) pops++;
         if (fifo_pop && wlast) last_pops++;
         tick();
      end
      checks++; if (pops !== 2)            begin errors++; $display("FAIL stall_w_pops got %0d exp 2", pops); end
      checks++; if (last_pops !== 1)       begin errors++; $display("FAIL stall_w_last got %0d exp 1", last_pops); end
      awready = 1'b1;
      tick(); #1;
      checks++; if (awvalid !== 1'b0)      begin errors++; $display("FAIL stall_aw_release got %b exp 0", awvalid); end
      b_pulse(2'b00); #1;
      checks++; if (wr_idle !== 1'b1)      begin errors++; $display("FAIL stall_idle got %b exp 1", wr_idle); end
   endtask

   task automatic test_fifo_empty();
      send_req(32'h4000, 8'd3, 4'hF, DMA_MODE_INCR);
      tick(); #1;
      checks++; if ({wvalid, wlast} !== 2'b10) begin errors++; $display("FAIL gap_beat0 got %b exp 10", {wvalid, wlast}); end
      tick(); #1;
      checks++; if ({wvalid, wlast} !== 2'b10) begin errors++; $display("FAIL gap_beat1 got %b exp 10", {wvalid, wlast}); end
      for (int i = 0; i < 3; i++) begin
         tick();
         fifo_empty = 1'b1;
         #1;
         checks++; if ({wvalid, fifo_pop, wlast} !== 3'b000)
            begin errors++; $display("FAIL gap_stalled cyc %0d got %b exp 000", i, {wvalid, fifo_pop, wlast}); end
      end
      tick();
      fifo_empty = 1'b0;
      #1;
      checks++; if ({wvalid, wlast} !== 2'b10) begin errors++; $display("FAIL gap_beat2 got %b exp 10", {wvalid, wlast}); end
      tick(); #1;
      checks++; if ({wvalid, wlast} !== 2'b11) begin errors++; $display("FAIL gap_beat3 got %b exp 11", {wvalid, wlast}); end
      tick(); #1;
      checks++; if (wvalid !== 1'b0)       begin errors++; $display("FAIL gap_done got %b exp 0", wvalid); end
      b_pulse(2'b00); #1;
      checks++; if (wr_idle !== 1'b1)      begin errors++; $display("FAIL gap_idle got %b exp 1", wr_idle); end
   endtask

   task automatic run_burst_b(input logic [31:0] a, input logic [1:0] r);
      send_req(a, 8'd0, 4'hF, DMA_MODE_INCR);
      tick(); tick();
      b_pulse(r);
      #1;
   endtask

   task automatic test_err_abort();
      int pops, last_pops;
      run_burst_b(32'h5000, 2'b00);
      checks++; if (wr_err !== 1'b0)       begin errors++; $display("FAIL err_after_okay got %b exp 0", wr_err); end
      run_burst_b(32'h5010, 2'b10);
      checks++; if (wr_err !== 1'b1)       begin errors++; $display("FAIL err_after_slverr got %b exp 1", wr_err); end
      run_burst_b(32'h5020, 2'b00);
      checks++; if (wr_err !== 1'b1)       begin errors++; $display("FAIL err_sticky got %b exp 1", wr_err); end
      checks++; if (wr_idle !== 1'b1)      begin errors++; $display("FAIL err_idle got %b exp 1", wr_idle); end

      pops = 0; last_pops = 0;
      send_req(32'h5100, 8'd2, 4'hF, DMA_MODE_INCR);
      abort = 1'b1;
      req.valid = 1'b1; req.addr = 32'h6000; req.alen = 8'd0;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++; if (resp.ready !== 1'b0) begin errors++; $display("FAIL abort_ready cyc %0d got %b exp 0", i, resp.ready); end
         if (fifo_pop) pops++;
         if (fifo_pop && wlast) last_pops++;
         tick();
      end
      checks++; if (pops !== 3)            begin errors++; $display("FAIL abort_beats got %0d exp 3", pops); end
      checks++; if (last_pops !== 1)       begin errors++; $display("FAIL abort_last got %0d exp 1", last_pops); end
      checks++; if (awvalid !== 1'b0)      begin errors++; $display("FAIL abort_no_new_aw got %b exp 0", awvalid); end
      b_pulse(2'b00); #1;
      checks++; if (wr_idle !== 1'b1)      begin errors++; $display("FAIL abort_idle got %b exp 1", wr_idle); end
      checks++; if (resp.ready !== 1'b0)   begin errors++; $display("FAIL abort_ready_idle got %b exp 0", resp.ready); end
      abort = 1'b0;
      req.valid = 1'b0;
      #1;
      checks++; if (resp.ready !== 1'b1)   begin errors++; $display("FAIL abort_release_ready got %b exp 1", resp.ready); end
   endtask

   task automatic test_reset_mid_burst();
      send_req(32'h7000, 8'd3, 4'hF, DMA_MODE_INCR);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++; if (wvalid !== 1'b0)       begin errors++; $display("FAIL rstmid_wvalid got %b exp 0", wvalid); end
      checks++; if (awvalid !== 1'b0)      begin errors++; $display("FAIL rstmid_awvalid got %b exp 0", awvalid); end
      checks++; if (wr_idle !== 1'b1)      begin errors++; $display("FAIL rstmid_idle got %b exp 1", wr_idle); end
      checks++; if (wr_err !== 1'b0)       begin errors++; $display("FAIL rstmid_err_cleared got %b exp 0", wr_err); end
      tick(); #1;
      checks++; if (resp.ready !== 1'b1)   begin errors++; $display("FAIL rstmid_ready got %b exp 1", resp.ready); end
      checks++; if (wvalid !== 1'b0)       begin errors++; $display("FAIL rstmid_no_resume got %b exp 0", wvalid); end
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      abort = 1'b0;
      awready = 1'b1;
      wready = 1'b1;
      bvalid = 1'b0;
      bresp = 2'b00;
      fifo_data = 32'h0;
      fifo_empty = 1'b0;

      test_reset();
      test_incr_burst();
      test_single_beat();
      test_outstanding();
      test_aw_stall();
      test_fifo_empty();
      test_err_abort();
      test_reset_mid_burst();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
